// File: rtl/qsys_irq_pkg.sv
// Shared constants for the Qsys interrupt aggregator: register map and
// VECTOR register layout.
package qsys_irq_pkg;

  localparam int IRQ_MAX       = 16;
  localparam int VEC_VALID_BIT = 15;

  typedef enum logic [2:0] {
    ADDR_PENDING = 3'd0,
    ADDR_MASK    = 3'd1,
    ADDR_EDGE    = 3'd2,
    ADDR_ACTIVE  = 3'd3,
    ADDR_VECTOR  = 3'd4,
    ADDR_RAW     = 3'd5,
    ADDR_FORCE   = 3'd6,
    ADDR_RSVD    = 3'd7
  } reg_addr_e;

endpackage

// File: rtl/qsys_irq_prio_enc.sv
// Lowest-index-wins priority encoder over up to 16 request lines.
module qsys_irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [3:0]         o_index
);

  // Scan from the top down so the last hit, the lowest set index, sticks.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_valid = 1'b0;
    o_index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/qsys_irq_ctrl.sv
// Avalon-MM interrupt aggregator: level/edge capture into PENDING, masking,
// registered CPU irq and a lowest-index VECTOR register with acknowledge.
module qsys_irq_ctrl
  import qsys_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] r_pending, r_mask, r_edge, r_irq_q;
  logic [15:0]        r_readdata;
  logic               r_irq_out;

  logic               w_wr;
  reg_addr_e          w_addr;
  logic [NUM_IRQ-1:0] w_wd, w_active, w_set, w_clr, w_pending_next;
  logic               w_vec_valid;
  logic [3:0]         w_vec_index;
  logic [15:0]        w_vector, w_rdata;
  logic               w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_addr      = reg_addr_e'(address);
  assign w_wd        = writedata[NUM_IRQ-1:0];
  assign w_active    = r_pending & r_mask;
  assign w_unused_wd = ^writedata;

  qsys_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .i_req   (w_active),
    .o_valid (w_vec_valid),
    .o_index (w_vec_index)
  );

  always_comb begin
    w_vector                = '0;
    w_vector[VEC_VALID_BIT] = w_vec_valid;
    w_vector[3:0]           = w_vec_index;
  end

  // Set beats clear, so a still-asserted level source re-pends after W1C/ack.
  always_comb begin
    w_set = (r_edge & irq_in & ~r_irq_q) | (~r_edge & irq_in);
    if (w_wr && w_addr == ADDR_FORCE) w_set = w_set | w_wd;
    w_clr = '0;
    if (w_wr && w_addr == ADDR_PENDING) w_clr = w_wd;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_wr && w_addr == ADDR_VECTOR && w_vec_valid && w_vec_index == 4'(i))
        w_clr[i] = 1'b1;
    end
    w_pending_next = w_set | (r_pending & ~w_clr);
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_PENDING: w_rdata = 16'(r_pending);
      ADDR_MASK:    w_rdata = 16'(r_mask);
      ADDR_EDGE:    w_rdata = 16'(r_edge);
      ADDR_ACTIVE:  w_rdata = 16'(w_active);
      ADDR_VECTOR:  w_rdata = w_vector;
      ADDR_RAW:     w_rdata = 16'(r_irq_q);
      default:      w_rdata = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_irq_q    <= '0;
      r_readdata <= '0;
      r_irq_out  <= 1'b0;
    end else begin
      r_pending  <= w_pending_next;
      r_irq_q    <= irq_in;
      r_readdata <= w_rdata;
      r_irq_out  <= |w_active;
      if (w_wr && w_addr == ADDR_MASK) r_mask <= w_wd;
      if (w_wr && w_addr == ADDR_EDGE) r_edge <= w_wd;
    end
  end

  assign readdata = r_readdata;
  assign irq_out  = r_irq_out;

endmodule

// File: tb/tb_qsys_irq_ctrl.sv
// Directed plus randomized bench for qsys_irq_ctrl against a behavioural
// register-level model.
module tb_qsys_irq_ctrl;

  localparam int N     = 8;
  localparam int NMASK = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [15:0]   readdata;
  logic          irq_out;

  int errors = 0;
  int checks = 0;

  int m_pend = 0, m_mask = 0, m_edge = 0, m_q = 0, m_rd = 0;
  bit m_irq = 1'b0;

  always #5 clk = ~clk;

  qsys_irq_ctrl #(.NUM_IRQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_out    (irq_out)
  );

  function automatic int m_vector(input int act);
    for (int i = 0; i < N; i++)
      if (act[i]) return 32'h8000 | i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies the register rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int act, vec, wd, in_v, rd, set_v, clr_v;
    bit wr;
    act  = m_pend & m_mask;
    vec  = m_vector(act);
    wr   = chipselect && !write_n;
    wd   = int'(writedata) & NMASK;
    in_v = int'(irq_in);
    case (address)
      3'd0:    rd = m_pend;
      3'd1:    rd = m_mask;
      3'd2:    rd = m_edge;
      3'd3:    rd = act;
      3'd4:    rd = vec;
      3'd5:    rd = m_q;
      default: rd = 0;
    endcase
    set_v = (in_v & ~m_q & m_edge) | (in_v & ~m_edge);
    if (wr && address == 3'd6) set_v = set_v | wd;
    clr_v = 0;
    if (wr && address == 3'd0) clr_v = wd;
    if (wr && address == 3'd4 && vec != 0) clr_v = clr_v | (1 << (vec & 15));
    if (reset) begin
      m_pend = 0; m_mask = 0; m_edge = 0; m_q = 0; m_rd = 0; m_irq = 1'b0;
    end else begin
      m_pend = (set_v | (m_pend & ~clr_v)) & NMASK;
      if (wr && address == 3'd1) m_mask = wd;
      if (wr && address == 3'd2) m_edge = wd;
      m_q   = in_v;
      m_rd  = rd;
      m_irq = (act != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("rdata_model", readdata, 16'(m_rd));
    check("irq_model", {15'b0, irq_out}, {15'b0, m_irq});
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    d = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [15:0] v;

    // Reset, then every address reads zero.
    tick(); tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check($sformatf("reset_read_a%0d", a), v, 16'h0000);
    end
    check("reset_irq_out", {15'b0, irq_out}, 16'h0000);

    // One-cycle edge pulse on bit 0.
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    check("edge_irq_at_capture", {15'b0, irq_out}, 16'h0000);
    irq_in = 8'h00;
    tick();
    check("edge_irq_next", {15'b0, irq_out}, 16'h0001);
    rd(3'd0, v);
    check("edge_pending", v, 16'h0001);
    wr(3'd0, 16'h0001);
    tick(); tick();
    check("edge_irq_cleared", {15'b0, irq_out}, 16'h0000);
    rd(3'd0, v);
    check("edge_pending_cleared", v, 16'h0000);

    // Level source held: W1C loses to set; release then W1C clears.
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    irq_in = 8'h04;
    tick();
    wr(3'd0, 16'h0004);
    rd(3'd0, v);
    check("level_set_wins", v, 16'h0004);
    irq_in = 8'h00;
    wr(3'd0, 16'h0004);
    rd(3'd0, v);
    check("level_cleared", v, 16'h0000);

    // FORCE and VECTOR acknowledge chain.
    wr(3'd6, 16'h0028);
    wr(3'd1, 16'h00FF);
    rd(3'd6, v);
    check("force_reads_zero", v, 16'h0000);
    rd(3'd4, v);
    check("vector_first", v, 16'h8003);
    wr(3'd4, 16'h0000);
    rd(3'd4, v);
    check("vector_second", v, 16'h8005);
    wr(3'd4, 16'h1234);
    rd(3'd4, v);
    check("vector_empty", v, 16'h0000);
    tick();
    check("vector_irq_low", {15'b0, irq_out}, 16'h0000);

    // Masked-out pending sources.
    wr(3'd1, 16'h0000);
    wr(3'd6, 16'h0011);
    tick(); tick();
    check("masked_irq_low", {15'b0, irq_out}, 16'h0000);
    rd(3'd3, v);
    check("masked_active", v, 16'h0000);
    rd(3'd0, v);
    check("masked_pending", v, 16'h0011);
    wr(3'd1, 16'h0001);
    check("unmask_irq_same_edge", {15'b0, irq_out}, 16'h0000);
    tick();
    check("unmask_irq_next", {15'b0, irq_out}, 16'h0001);

    // Mid-operation reset with irq_in[1] held high.
    wr(3'd0, 16'h00FF);
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h0002);
    irq_in = 8'h02;
    tick();
    rd(3'd0, v);
    check("pre_reset_pending", v, 16'h0002);
    reset = 1'b1;
    tick();
    check("in_reset_rdata", readdata, 16'h0000);
    check("in_reset_irq", {15'b0, irq_out}, 16'h0000);
    reset = 1'b0;
    tick();
    rd(3'd0, v);
    check("post_reset_recapture", v, 16'h0002);
    rd(3'd2, v);
    check("post_reset_edge", v, 16'h0000);
    irq_in = 8'h00;

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      irq_in     = N'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = 16'($urandom);
      reset      = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
